// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: keypad digits shift in, count decrements per enabled clock.
// Optional macro TIMER_MMSS_EN makes digits 1:0 a seconds field (digit 1 wraps 0 -> 5).
module bcd_countdown_timer #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    clearn,
    input  logic [3:0]              data,
    input  logic                    loadn,
    input  logic                    EN,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    zero,
    output logic                    done,
    output logic                    running,
    output logic                    err
);

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_zero;
    logic                    r_done;
    logic                    r_err;

    logic [4*NUM_DIGITS-1:0] w_decDigits;
    logic [4*NUM_DIGITS-1:0] w_nextDigits;
    logic                    w_dataValid;
    logic                    w_dec;

    // Ripple borrow from digit 0 upward; top-digit borrow-out cannot occur since count is nonzero.
    always_comb begin
        logic w_borrow;
        w_borrow    = 1'b1;
        w_decDigits = r_digits;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_borrow) begin
                if (r_digits[4*k +: 4] == 4'd0) begin
`ifdef TIMER_MMSS_EN
                    w_decDigits[4*k +: 4] = (k == 1) ? 4'd5 : 4'd9;
`else
                    w_decDigits[4*k +: 4] = 4'd9;
`endif
                    w_borrow = 1'b1;
                end else begin
                    w_decDigits[4*k +: 4] = r_digits[4*k +: 4] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
    end

    assign w_dataValid = (data <= 4'd9);
    assign w_dec       = loadn && EN && !r_zero;

    always_comb begin
        w_nextDigits = r_digits;
        if (!loadn) begin
            if (w_dataValid) begin
                w_nextDigits = {r_digits[4*NUM_DIGITS-5:0], data};
            end
        end else if (w_dec) begin
            w_nextDigits = w_decDigits;
        end
    end

    always_ff @(posedge clk) begin
        if (!clearn) begin
            r_digits <= '0;
            r_zero   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_digits <= w_nextDigits;
            r_zero   <= (w_nextDigits == '0);
            r_done   <= w_dec && (w_decDigits == '0);
            r_err    <= !loadn && !w_dataValid;
        end
    end

    assign digits  = r_digits;
    assign zero    = r_zero;
    assign done    = r_done;
    assign err     = r_err;
    assign running = EN && !r_zero && loadn;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: directed cases plus random traffic against a
// decimal-integer model of the count. Honours TIMER_MMSS_EN in the same way as the design.
module tb_bcd_countdown_timer;

    localparam int NUM_DIGITS = 4;
    localparam int W = 4 * NUM_DIGITS;

    logic         clk = 1'b0;
    logic         clearn;
    logic [3:0]   data;
    logic         loadn;
    logic         EN;
    logic [W-1:0] digits;
    logic         zero;
    logic         done;
    logic         running;
    logic         err;

    int checkCount = 0;
    int failCount  = 0;
    int modelCount = 0;
    int modulus    = 1;

    bcd_countdown_timer #(.NUM_DIGITS(NUM_DIGITS)) dut (
        .clk     (clk),
        .clearn  (clearn),
        .data    (data),
        .loadn   (loadn),
        .EN      (EN),
        .digits  (digits),
        .zero    (zero),
        .done    (done),
        .running (running),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] toBcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // In MM:SS mode an empty seconds field borrows a minute and becomes 59 (net -41 in decimal).
    function automatic int decrementValue(input int v);
`ifdef TIMER_MMSS_EN
        if (v % 100 == 0) return v - 41;
`endif
        return v - 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic cl, input logic ld, input logic en, input logic [3:0] d);
        logic expDone;
        logic expErr;
        clearn = cl;
        loadn  = ld;
        EN     = en;
        data   = d;
        #1;
        checkOutput("running", 32'(running), 32'(en && ld && (modelCount != 0)));
        @(posedge clk);
        expDone = 1'b0;
        expErr  = 1'b0;
        if (!cl) begin
            modelCount = 0;
        end else if (!ld) begin
            if (d <= 4'd9) modelCount = (modelCount * 10 + int'(d)) % modulus;
            else           expErr = 1'b1;
        end else if (en && modelCount != 0) begin
            modelCount = decrementValue(modelCount);
            expDone    = (modelCount == 0);
        end
        #1;
        checkOutput("digits", 32'(digits), 32'(toBcd(modelCount)));
        checkOutput("zero",   32'(zero),   32'(modelCount == 0));
        checkOutput("done",   32'(done),   32'(expDone));
        checkOutput("err",    32'(err),    32'(expErr));
    endtask

    task automatic loadDigit(input logic [3:0] d);
        applyStimulus(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic clearTimer();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        for (int k = 0; k < NUM_DIGITS; k++) modulus = modulus * 10;

        clearn = 1'b0;
        loadn  = 1'b1;
        EN     = 1'b0;
        data   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        modelCount = 0;
        checkOutput("resetDigits",  32'(digits),  32'h0);
        checkOutput("resetZero",    32'(zero),    32'h1);
        checkOutput("resetDone",    32'(done),    32'h0);
        checkOutput("resetRunning", 32'(running), 32'h0);

        // Keypad entry with top digit dropped
        loadDigit(4'd1);
        loadDigit(4'd3);
        loadDigit(4'd0);
        checkOutput("entry0130", 32'(digits), 32'h0130);
        loadDigit(4'd7);
        checkOutput("entry1307", 32'(digits), 32'h1307);
        loadDigit(4'd2);
        checkOutput("entry3072", 32'(digits), 32'h3072);

        clearTimer();
        loadDigit(4'd4);
        loadDigit(4'd2);
        loadDigit(4'hC);
        checkOutput("invalidHold", 32'(digits), 32'h0042);
        checkOutput("invalidErr",  32'(err),    32'h1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
        checkOutput("errPulseEnd", 32'(err),    32'h0);

        clearTimer();
        loadDigit(4'd1);
        loadDigit(4'd0);
        loadDigit(4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
`ifdef TIMER_MMSS_EN
        checkOutput("borrow1", 32'(digits), 32'h0059);
`else
        checkOutput("borrow1", 32'(digits), 32'h0099);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
`ifdef TIMER_MMSS_EN
        checkOutput("borrow2", 32'(digits), 32'h0058);
`else
        checkOutput("borrow2", 32'(digits), 32'h0098);
`endif

        clearTimer();
        loadDigit(4'd3);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("run2", 32'(digits), 32'h0002);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("run1", 32'(digits), 32'h0001);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("run0",     32'(digits), 32'h0000);
        checkOutput("runDone",  32'(done),   32'h1);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
        checkOutput("noWrap",   32'(digits), 32'h0000);
        checkOutput("noRepulse", 32'(done),  32'h0);
        checkOutput("stayZero", 32'(zero),   32'h1);
        loadDigit(4'd0);
        checkOutput("zeroLoadDone", 32'(done), 32'h0);

        clearTimer();
        loadDigit(4'd1);
        loadDigit(4'd2);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
        checkOutput("loadWins", 32'(digits), 32'h0125);

        clearTimer();
        loadDigit(4'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("clearWinsDone", 32'(done), 32'h0);

        // Random traffic, biased toward zeros so counts actually reach zero
        for (int i = 0; i < 3000; i++) begin
            logic       cl;
            logic       ld;
            logic       en;
            logic [3:0] d;
            cl = ($urandom_range(0, 59) != 0);
            ld = ($urandom_range(0, 5) != 0);
            en = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       d = 4'($urandom_range(10, 15));
                1:       d = 4'($urandom_range(0, 9));
                default: d = 4'd0;
            endcase
            applyStimulus(cl, ld, en, d);
        end

        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);
        checkOutput("finalClearDigits",  32'(digits),  32'h0);
        checkOutput("finalClearRunning", 32'(running), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer for the microwave controller datapath. Successor to the single-digit timer: keypad digits are shifted in one at a time, the count decrements once per enabled clock, and the block flags both the zero state and the zero-reaching event. It sits between the keypad encoder, which supplies `data` and `loadn`, and the control FSM and display driver, which consume `digits`, `zero` and `done`.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: number of BCD digits, legal range 2..8. Digit 0 is least significant.

Ports:
- `clk` input 1: single clock. All state changes on the rising edge.
- `clearn` input 1: reset, synchronous and active-low. Clears all digits.
- `data` input 4: BCD digit to shift in. Values 10..15 are invalid.
- `loadn` input 1: active-low digit-entry strobe, one digit per cycle held low.
- `EN` input 1: count enable. Decrements once per clock while high.
- `digits` output 4*NUM_DIGITS: current count. Digit k occupies bits [4k+3:4k].
- `zero` output 1: high when all digits are 0.
- `done` output 1: one-cycle pulse when a decrement brings the count to zero.
- `running` output 1: high when EN=1, count is nonzero and loadn=1.
- `err` output 1: one-cycle pulse on a load attempt with invalid `data`.

## Operation
- Priority per cycle: clearn=0, then loadn=0, then EN=1, else hold.
- Clear (clearn=0):
  - digits=0, zero=1, done=0, err=0.
  - running is combinational, so it reads 0 while zero=1.
- Load (loadn=0, data≤9):
  - digits shift left by one digit: digit k ← digit k-1, digit 0 ← data.
  - The top digit is discarded.
  - No decrement occurs that cycle, even with EN=1.
- Load (loadn=0, data>9):
  - Digits unchanged.
  - err pulses the next cycle.
  - No decrement occurs that cycle.
- Decrement (EN=1, loadn=1, count nonzero):
  - Subtract 1 with BCD borrow chain.
  - A digit at 0 that receives a borrow wraps to 9, or to 5 for the seconds-tens digit in MM:SS mode.
- At zero: EN has no effect. No wrap to all-nines. done does not re-pulse.
- done:
  - Registered; high for exactly the cycle after the edge where a decrement makes the count zero.
  - Never asserted by clear or by a load of zeros.
- Loaded digits are never normalised. Example: in MM:SS mode a loaded 0:90 decrements 0:90 → 0:89 → … → 0:00.

## Timing
- `digits`, `zero`, `done`, `err`: registered, valid from the edge that caused the change.
- Latency: load or decrement is visible one clock after the enabling edge.
- Reset is synchronous: the clear takes effect on the first rising edge with clearn=0.
- Reset mid-count: the count is lost and done is not asserted.
- Load during a run (EN=1, loadn=0): the load wins that cycle, and counting resumes on the next cycle with loadn=1.
- Count reaching zero on the same edge as clearn=0: the clear wins, done=0.
- Width rule: internal per-digit subtract is 4 bits with a 1-bit borrow. The borrow out of the top digit is not possible, because the count is guarded nonzero.

## Configuration
- `TIMER_MMSS_EN` defined:
  - Digits 1:0 are seconds. Digit 1 wraps 0 → 5 on borrow, so 1:00 → 0:59.
  - Higher digits are minutes in plain BCD.
- `TIMER_MMSS_EN` undefined: every digit wraps 0 → 9, giving a pure decimal countdown (100 → 099).

## Test plan
- Reset:
  - Stimulus: clearn=0 for 1 cycle after random activity.
  - Required response: digits=0, zero=1, done=0, running=0.
- Entry:
  - Stimulus: NUM_DIGITS=4; loadn pulses with data 1, 3, 0 on successive cycles.
  - Required response: digits=0x0130.
  - Stimulus: then enter 7, 2.
  - Required response: digits=0x1307, then 0x3072 (top digit dropped).
- Invalid entry:
  - Stimulus: load data=4'hC with digits=0x0042.
  - Required response: digits stay 0x0042, err=1 for one cycle.
- MM:SS borrow (TIMER_MMSS_EN):
  - Stimulus: load 0x0100, then EN=1.
  - Required response: 0x0059, 0x0058 on successive clocks.
  - Without the macro, the same stimulus must give 0x0099.
- Run to zero:
  - Stimulus: load 0x0003, EN=1 held.
  - Required response: 2, 1, 0. done=1 for one cycle only, zero stays 1, no wrap.
- Collisions:
  - Stimulus: EN=1 and loadn=0 with data=5 at count 0x0012.
  - Required response: 0x0125, with no decrement in that cycle.
  - Stimulus: clearn=0 on the same edge the count would reach 0.
  - Required response: done=0.
